// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr
// Purpose     : round-robin owner selection for the shared system bus; one registered one-hot
//               grant, held from begin-transaction until end-transaction or bus error.
// Latency     : a request sampled at an IDLE edge is granted by that same edge's flops; after a
//               release the bus is ungranted for two cycles (RELEASE, then IDLE arbitration).
// Backpressure: none; requests are level signals held until granted, and there is no preemption.
//
// Optional feature macro: ARBITER_TIMEOUT_EN (adds a GRANTED/BUSY watchdog that forces a release
// and pulses busErrorOut; without it busErrorOut is tied 0 and a hung owner keeps the bus).
//
// Ports:
//   clock              in   system clock, all state on the rising edge
//   reset              in   asynchronous active-high reset
//   request            in   [NR_MASTERS] level request per master
//   beginTransactionIn in   OR of all masters' begin-transaction strobes
//   endTransactionIn   in   end-of-transaction strobe
//   busErrorIn         in   bus error from the slave
//   transactionGranted out  [NR_MASTERS] registered one-hot grant
//   activeMaster       out  [3] index of the granted master, valid while busIdle=0
//   busIdle            out  1 when no grant is outstanding
//   busErrorOut        out  one-cycle watchdog expiry pulse
module bus_arbiter_rr #(
  parameter int NR_MASTERS     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NR_MASTERS-1:0] request,
  input  logic                  beginTransactionIn,
  input  logic                  endTransactionIn,
  input  logic                  busErrorIn,
  output logic [NR_MASTERS-1:0] transactionGranted,
  output logic [2:0]            activeMaster,
  output logic                  busIdle,
  output logic                  busErrorOut
);

  // Elaboration-time parameter range checks.
  if (NR_MASTERS < 2 || NR_MASTERS > 8) begin : g_bad_nr_masters
    $error("bus_arbiter_rr: NR_MASTERS must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("bus_arbiter_rr: TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANTED = 2'd1;
  localparam logic [1:0] ST_BUSY    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [1:0]            state;
  logic [2:0]            last_grant;
  logic [NR_MASTERS-1:0] grant_q;
  logic [2:0]            active_q;
  logic                  idle_q;

  // ------------------------------------------------------------------
  // Round-robin selection: prefer requesters strictly above last_grant,
  // otherwise wrap to the lowest requester overall.
  // ------------------------------------------------------------------
  logic [NR_MASTERS-1:0] above_mask;
  logic [NR_MASTERS-1:0] req_hi;
  logic [NR_MASTERS-1:0] req_pick;
  logic [NR_MASTERS-1:0] sel_onehot;
  logic [2:0]            sel_idx;
  logic                  any_req;

  always_comb begin
    above_mask = '0;
    for (int i = 0; i < NR_MASTERS; i++) begin
      above_mask[i] = (3'(i) > last_grant);
    end
    req_hi   = request & above_mask;
    req_pick = (|req_hi) ? req_hi : request;
    any_req  = |request;

    // Scan downward so the lowest set bit is the last one written.
    sel_idx    = '0;
    sel_onehot = '0;
    for (int i = NR_MASTERS - 1; i >= 0; i--) begin
      if (req_pick[i]) begin
        sel_idx       = 3'(i);
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Owner still wants the bus (one-hot grant avoids indexing by activeMaster).
  logic owner_req;
  assign owner_req = |(request & grant_q);

  // ------------------------------------------------------------------
  // Optional watchdog
  // ------------------------------------------------------------------
  logic wd_expire;

`ifdef ARBITER_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        err_q;
  logic        holding;

  assign holding   = (state == ST_GRANTED) || (state == ST_BUSY);
  assign wd_expire = holding && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      // Pulse coincides with the grant-dropping edge; next cycle is RELEASE so it self-clears.
      err_q <= wd_expire;
      if (state == ST_IDLE && any_req) begin
        wd_cnt <= '0;
      end else if (holding) begin
        wd_cnt <= wd_cnt + 16'd1;
      end
    end
  end

  assign busErrorOut = err_q;
`else
  assign wd_expire   = 1'b0;
  assign busErrorOut = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Ownership FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant_q    <= '0;
      active_q   <= '0;
      idle_q     <= 1'b1;
      last_grant <= 3'(NR_MASTERS - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          // Stray begin/end strobes are ignored here.
          if (any_req) begin
            state      <= ST_GRANTED;
            grant_q    <= sel_onehot;
            active_q   <= sel_idx;
            idle_q     <= 1'b0;
            last_grant <= sel_idx;
          end
        end
        ST_GRANTED: begin
          if (wd_expire) begin
            state   <= ST_RELEASE;
            grant_q <= '0;
            idle_q  <= 1'b1;
          end else if (beginTransactionIn) begin
            state <= ST_BUSY;
          end else if (!owner_req) begin
            // Owner abandoned the grant before starting a transaction.
            state   <= ST_RELEASE;
            grant_q <= '0;
            idle_q  <= 1'b1;
          end
        end
        ST_BUSY: begin
          // end and error together collapse into one release.
          if (wd_expire || endTransactionIn || busErrorIn) begin
            state   <= ST_RELEASE;
            grant_q <= '0;
            idle_q  <= 1'b1;
          end
        end
        default: begin
          // RELEASE: one turnaround cycle with no owner.
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign transactionGranted = grant_q;
  assign activeMaster       = active_q;
  assign busIdle            = idle_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
module tb_bus_arbiter_rr;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] request = '0;
  logic         beginTransactionIn = 1'b0;
  logic         endTransactionIn = 1'b0;
  logic         busErrorIn = 1'b0;
  logic [N-1:0] transactionGranted;
  logic [2:0]   activeMaster;
  logic         busIdle;
  logic         busErrorOut;

  int n_cmp = 0;
  int n_bad = 0;

  bus_arbiter_rr #(
    .NR_MASTERS    (N),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .request           (request),
    .beginTransactionIn(beginTransactionIn),
    .endTransactionIn  (endTransactionIn),
    .busErrorIn        (busErrorIn),
    .transactionGranted(transactionGranted),
    .activeMaster      (activeMaster),
    .busIdle           (busIdle),
    .busErrorOut       (busErrorOut)
  );

  initial forever #5 clock = ~clock;

  // Advance past the next rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    request            = '0;
    beginTransactionIn = 1'b0;
    endTransactionIn   = 1'b0;
    busErrorIn         = 1'b0;
    reset              = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    step();
    n_cmp++;
    if (transactionGranted !== 4'b0000) begin
      n_bad++; $display("FAIL reset_grant: got %b want %b", transactionGranted, 4'b0000);
    end
    n_cmp++;
    if (activeMaster !== 3'd0) begin
      n_bad++; $display("FAIL reset_active: got %0d want 0", activeMaster);
    end
    n_cmp++;
    if (busIdle !== 1'b1) begin
      n_bad++; $display("FAIL reset_idle: got %b want 1", busIdle);
    end
    n_cmp++;
    if (busErrorOut !== 1'b0) begin
      n_bad++; $display("FAIL reset_buserr: got %b want 0", busErrorOut);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    request = 4'b0001;
    n_cmp++;
    if (transactionGranted !== 4'b0000) begin
      n_bad++; $display("FAIL single_pre_grant: got %b want %b", transactionGranted, 4'b0000);
    end
    step();
    n_cmp++;
    if (transactionGranted !== 4'b0001 || activeMaster !== 3'd0 || busIdle !== 1'b0) begin
      n_bad++; $display("FAIL single_grant: got %b/%0d/%b want 0001/0/0",
                        transactionGranted, activeMaster, busIdle);
    end
    beginTransactionIn = 1'b1;
    request            = 4'b0000;
    step();
    beginTransactionIn = 1'b0;
    repeat (8) step();
    n_cmp++;
    if (transactionGranted !== 4'b0001 || busIdle !== 1'b0) begin
      n_bad++; $display("FAIL single_busy_hold: got %b/%b want 0001/0", transactionGranted, busIdle);
    end
    endTransactionIn = 1'b1;
    step();
    endTransactionIn = 1'b0;
    n_cmp++;
    if (transactionGranted !== 4'b0000 || busIdle !== 1'b1) begin
      n_bad++; $display("FAIL single_release: got %b/%b want 0000/1", transactionGranted, busIdle);
    end
    step();
    n_cmp++;
    if (transactionGranted !== 4'b0000 || busIdle !== 1'b1) begin
      n_bad++; $display("FAIL single_idle_after: got %b/%b want 0000/1", transactionGranted, busIdle);
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] exp_g [5];
    logic [2:0]   exp_a [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_a = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    do_reset();
    request = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (transactionGranted !== exp_g[k] || activeMaster !== exp_a[k]) begin
        n_bad++; $display("FAIL rotation_grant[%0d]: got %b/%0d want %b/%0d",
                          k, transactionGranted, activeMaster, exp_g[k], exp_a[k]);
      end
      beginTransactionIn = 1'b1;
      step();
      beginTransactionIn = 1'b0;
      endTransactionIn   = 1'b1;
      step();
      endTransactionIn = 1'b0;
      n_cmp++;
      if (transactionGranted !== 4'b0000 || busIdle !== 1'b1) begin
        n_bad++; $display("FAIL rotation_gap[%0d]: got %b/%b want 0000/1", k, transactionGranted, busIdle);
      end
      step();
    end
    request = '0;
  endtask

  task automatic test_abandon();
    do_reset();
    request = 4'b0100;
    step();
    n_cmp++;
    if (transactionGranted !== 4'b0100 || activeMaster !== 3'd2) begin
      n_bad++; $display("FAIL abandon_grant2: got %b/%0d want 0100/2", transactionGranted, activeMaster);
    end
    request = 4'b1011;
    step();
    n_cmp++;
    if (transactionGranted !== 4'b0000 || busIdle !== 1'b1) begin
      n_bad++; $display("FAIL abandon_release: got %b/%b want 0000/1", transactionGranted, busIdle);
    end
    step();
    step();
    n_cmp++;
    if (transactionGranted !== 4'b1000 || activeMaster !== 3'd3) begin
      n_bad++; $display("FAIL abandon_next_above: got %b/%0d want 1000/3", transactionGranted, activeMaster);
    end
    beginTransactionIn = 1'b1;
    request            = 4'b0011;
    step();
    beginTransactionIn = 1'b0;
    endTransactionIn   = 1'b1;
    step();
    endTransactionIn = 1'b0;
    step();
    step();
    n_cmp++;
    if (transactionGranted !== 4'b0001 || activeMaster !== 3'd0) begin
      n_bad++; $display("FAIL abandon_wrap: got %b/%0d want 0001/0", transactionGranted, activeMaster);
    end
  endtask

  // Continues from test_abandon: master 0 holds the grant, request=0011.
  task automatic test_end_and_error();
    beginTransactionIn = 1'b1;
    step();
    beginTransactionIn = 1'b0;
    endTransactionIn   = 1'b1;
    busErrorIn         = 1'b1;
    step();
    endTransactionIn = 1'b0;
    busErrorIn       = 1'b0;
    n_cmp++;
    if (transactionGranted !== 4'b0000 || busIdle !== 1'b1 || busErrorOut !== 1'b0) begin
      n_bad++; $display("FAIL enderr_release: got %b/%b/%b want 0000/1/0",
                        transactionGranted, busIdle, busErrorOut);
    end
    step();
    n_cmp++;
    if (transactionGranted !== 4'b0000) begin
      n_bad++; $display("FAIL enderr_idle: got %b want 0000", transactionGranted);
    end
    step();
    n_cmp++;
    if (transactionGranted !== 4'b0010 || activeMaster !== 3'd1) begin
      n_bad++; $display("FAIL enderr_next: got %b/%0d want 0010/1", transactionGranted, activeMaster);
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    request = 4'b1000;
    step();
    n_cmp++;
    if (transactionGranted !== 4'b1000) begin
      n_bad++; $display("FAIL midrst_grant3: got %b want 1000", transactionGranted);
    end
    beginTransactionIn = 1'b1;
    step();
    beginTransactionIn = 1'b0;
    request            = 4'b1111;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (transactionGranted !== 4'b0000 || busIdle !== 1'b1) begin
      n_bad++; $display("FAIL midrst_async_drop: got %b/%b want 0000/1", transactionGranted, busIdle);
    end
    step();
    reset = 1'b0;
    step();
    n_cmp++;
    if (transactionGranted !== 4'b0001 || activeMaster !== 3'd0) begin
      n_bad++; $display("FAIL midrst_pointer_reload: got %b/%0d want 0001/0", transactionGranted, activeMaster);
    end
    request = '0;
  endtask

  task automatic test_stray_pulses();
    do_reset();
    beginTransactionIn = 1'b1;
    endTransactionIn   = 1'b1;
    step();
    beginTransactionIn = 1'b0;
    endTransactionIn   = 1'b0;
    n_cmp++;
    if (transactionGranted !== 4'b0000 || busIdle !== 1'b1) begin
      n_bad++; $display("FAIL stray_idle: got %b/%b want 0000/1", transactionGranted, busIdle);
    end
    request = 4'b0010;
    step();
    n_cmp++;
    if (transactionGranted !== 4'b0010 || activeMaster !== 3'd1) begin
      n_bad++; $display("FAIL stray_then_grant: got %b/%0d want 0010/1", transactionGranted, activeMaster);
    end
    request = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    request = 4'b0001;
    step();
    n_cmp++;
    if (transactionGranted !== 4'b0001) begin
      n_bad++; $display("FAIL timeout_grant: got %b want 0001", transactionGranted);
    end
`ifdef ARBITER_TIMEOUT_EN
    for (int c = 1; c < 16; c++) begin
      step();
      n_cmp++;
      if (transactionGranted !== 4'b0001 || busErrorOut !== 1'b0) begin
        n_bad++; $display("FAIL timeout_hold[%0d]: got %b/%b want 0001/0", c, transactionGranted, busErrorOut);
      end
    end
    step();
    n_cmp++;
    if (transactionGranted !== 4'b0000 || busErrorOut !== 1'b1) begin
      n_bad++; $display("FAIL timeout_expire: got %b/%b want 0000/1", transactionGranted, busErrorOut);
    end
    step();
    n_cmp++;
    if (busErrorOut !== 1'b0) begin
      n_bad++; $display("FAIL timeout_pulse_width: got %b want 0", busErrorOut);
    end
`else
    for (int c = 1; c <= 40; c++) begin
      step();
      n_cmp++;
      if (transactionGranted !== 4'b0001 || busErrorOut !== 1'b0) begin
        n_bad++; $display("FAIL hung_hold[%0d]: got %b/%b want 0001/0", c, transactionGranted, busErrorOut);
      end
    end
`endif
    request = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_abandon();
    test_end_and_error();
    test_reset_mid_busy();
    test_stray_pulses();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
